scoreboard_lsu_region: RTL and testbench

Parametrised LSU address-decode scoreboard for N memory-mapped regions. Each region has a configurable base and size. The block computes the expected one-hot select vector from the driven address and delays it by the DUT's decode latency. Every cycle it compares that delayed vector against the DUT's actual select vector. It keeps per-region hit counters, unmapped and error counters, a sticky error flag, and a first-error capture record. It sits in 01_bench beside the other scoreboards and is bound to the LSU select outputs.

---
 rtl/singlecycle_pkg.sv | 35 +++
 rtl/lsu_exp_decode.sv | 27 ++
 rtl/scoreboard_lsu_region.sv | 203 ++++++++++++++++++++
 tb/tb_scoreboard_lsu_region.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/singlecycle_pkg.sv
// Shared constants for the single-cycle core: memory map, LSU region table
// and the scoreboard state encoding.
package singlecycle_pkg;

    localparam int LSU_NUM_REGION = 8;
    localparam int LSU_ADDR_W     = 32;

    localparam logic [31:0] DATA_BASE  = 32'h0000_2000;
    localparam logic [31:0] DATA_END   = 32'h0000_3FFF;
    localparam logic [31:0] LEDR_BASE  = 32'h0000_7000;
    localparam logic [31:0] LEDG_BASE  = 32'h0000_7010;
    localparam logic [31:0] SEG7_BASE  = 32'h0000_7020;
    localparam logic [31:0] LCD_BASE   = 32'h0000_7030;
    localparam logic [31:0] SW_BASE    = 32'h0000_7800;
    localparam logic [31:0] BTN_BASE   = 32'h0000_7810;
    localparam logic [31:0] TIMER_BASE = 32'h0000_7820;

    // Index 0 is the data RAM; concatenation lists the highest index first.
    localparam logic [LSU_NUM_REGION-1:0][LSU_ADDR_W-1:0] LSU_REGION_BASE = {
        TIMER_BASE, BTN_BASE, SW_BASE, LCD_BASE,
        SEG7_BASE, LEDG_BASE, LEDR_BASE, DATA_BASE
    };

    localparam logic [LSU_NUM_REGION-1:0][LSU_ADDR_W-1:0] LSU_REGION_SIZE = {
        32'd16, 32'd4, 32'd4, 32'd4,
        32'd8, 32'd4, 32'd4, DATA_END - DATA_BASE + 32'd1
    };

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOGGED = 2'd1,
        ST_FAIL   = 2'd2
    } sb_state_e;

endpackage

// File: rtl/lsu_exp_decode.sv
// Combinational address-to-region decode producing the expected select vector.
// Bounds are evaluated one bit wider so a region ending at 2^ADDR_W does not wrap.
module lsu_exp_decode #(
    parameter int NUM_REGION = 8,
    parameter int ADDR_W     = 32,
    parameter logic [NUM_REGION-1:0][ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGION-1:0][ADDR_W-1:0] REGION_SIZE = '0
) (
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [NUM_REGION-1:0] o_exp
);

    logic [ADDR_W:0] addr_x;

    assign addr_x = {1'b0, i_addr};

    always_comb begin
        o_exp = '0;
        for (int k = 0; k < NUM_REGION; k++) begin
            o_exp[k] = i_valid
                    && (addr_x >= {1'b0, REGION_BASE[k]})
                    && (addr_x <  ({1'b0, REGION_BASE[k]} + {1'b0, REGION_SIZE[k]}));
        end
    end

endmodule

// File: rtl/scoreboard_lsu_region.sv
// LSU select scoreboard: delays the expected region decode by the DUT latency,
// compares it every cycle against the DUT select vector and keeps statistics.
module scoreboard_lsu_region
    import singlecycle_pkg::*;
#(
    parameter int NUM_REGION = LSU_NUM_REGION,
    parameter int ADDR_W     = LSU_ADDR_W,
    parameter int LATENCY    = 0,
    parameter int CNT_W      = 16,
    parameter logic [NUM_REGION-1:0][ADDR_W-1:0] REGION_BASE = LSU_REGION_BASE,
    parameter logic [NUM_REGION-1:0][ADDR_W-1:0] REGION_SIZE = LSU_REGION_SIZE,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clr,
    input  logic                        i_drv_valid,
    input  logic [ADDR_W-1:0]           i_drv_addr,
    input  logic [NUM_REGION-1:0]       i_act_vld,
    output logic                        o_err,
    output logic                        o_cfg_err,
    output logic [CNT_W-1:0]            o_err_cnt,
    output logic [CNT_W-1:0]            o_txn_cnt,
    output logic [CNT_W-1:0]            o_unmapped_cnt,
    output logic [NUM_REGION*CNT_W-1:0] o_hit_cnt,
    output logic [ADDR_W-1:0]           o_first_addr,
    output logic [NUM_REGION-1:0]       o_first_exp,
    output logic [NUM_REGION-1:0]       o_first_act,
    output sb_state_e                   o_state
);

    logic [NUM_REGION-1:0] exp_now;
    logic                  dly_valid;
    logic [ADDR_W-1:0]     dly_addr;
    logic [NUM_REGION-1:0] dly_exp;
    logic                  mismatch;

    lsu_exp_decode #(
        .NUM_REGION  (NUM_REGION),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE)
    ) u_decode (
        .i_valid (i_drv_valid),
        .i_addr  (i_drv_addr),
        .o_exp   (exp_now)
    );

    // Delay line aligns the expectation with the DUT's select output.
    generate
        if (LATENCY == 0) begin : g_nodly
            assign dly_valid = i_drv_valid;
            assign dly_addr  = i_drv_addr;
            assign dly_exp   = exp_now;
        end else begin : g_dly
            logic [LATENCY-1:0]                 vld_q;
            logic [LATENCY-1:0][ADDR_W-1:0]     addr_q;
            logic [LATENCY-1:0][NUM_REGION-1:0] exp_q;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    vld_q  <= '0;
                    addr_q <= '0;
                    exp_q  <= '0;
                end else begin
                    vld_q[0]  <= i_drv_valid;
                    addr_q[0] <= i_drv_addr;
                    exp_q[0]  <= exp_now;
                    for (int s = 1; s < LATENCY; s++) begin
                        vld_q[s]  <= vld_q[s-1];
                        addr_q[s] <= addr_q[s-1];
                        exp_q[s]  <= exp_q[s-1];
                    end
                end
            end

            assign dly_valid = vld_q[LATENCY-1];
            assign dly_addr  = addr_q[LATENCY-1];
            assign dly_exp   = exp_q[LATENCY-1];
        end
    endgenerate

    assign mismatch = (dly_exp != i_act_vld);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
    endfunction

    sb_state_e state_q, state_d;
    logic      cnt_en;
    logic      capture_en;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clr) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:    if (mismatch) state_d = STOP_ON_ERR ? ST_FAIL : ST_LOGGED;
                ST_LOGGED: state_d = ST_LOGGED;
                ST_FAIL:   state_d = ST_FAIL;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // A clear in the same cycle as a mismatch suppresses that mismatch entirely.
    always_comb begin
        cnt_en     = (state_q != ST_FAIL) && !i_clr;
        capture_en = (state_q == ST_RUN) && mismatch && !i_clr;
    end

    logic                                err_q, err_d;
    logic                                cfg_q, cfg_d;
    logic [CNT_W-1:0]                    err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]                    txn_q, txn_d;
    logic [CNT_W-1:0]                    unm_q, unm_d;
    logic [NUM_REGION-1:0][CNT_W-1:0]    hit_q, hit_d;
    logic [ADDR_W-1:0]                   first_addr_q, first_addr_d;
    logic [NUM_REGION-1:0]               first_exp_q, first_exp_d;
    logic [NUM_REGION-1:0]               first_act_q, first_act_d;

    always_comb begin
        err_d        = err_q;
        cfg_d        = cfg_q;
        err_cnt_d    = err_cnt_q;
        txn_d        = txn_q;
        unm_d        = unm_q;
        hit_d        = hit_q;
        first_addr_d = first_addr_q;
        first_exp_d  = first_exp_q;
        first_act_d  = first_act_q;
        if (i_clr) begin
            err_d        = 1'b0;
            cfg_d        = 1'b0;
            err_cnt_d    = '0;
            txn_d        = '0;
            unm_d        = '0;
            hit_d        = '0;
            first_addr_d = '0;
            first_exp_d  = '0;
            first_act_d  = '0;
        end else if (cnt_en) begin
            txn_d     = sat_inc(txn_q, dly_valid);
            unm_d     = sat_inc(unm_q, dly_valid && (dly_exp == '0));
            err_cnt_d = sat_inc(err_cnt_q, mismatch);
            for (int k = 0; k < NUM_REGION; k++) begin
                hit_d[k] = sat_inc(hit_q[k], dly_exp[k]);
            end
            if (mismatch) err_d = 1'b1;
            if ($countones(dly_exp) > 1) cfg_d = 1'b1;
        end
        if (capture_en) begin
            first_addr_d = dly_addr;
            first_exp_d  = dly_exp;
            first_act_d  = i_act_vld;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q        <= 1'b0;
            cfg_q        <= 1'b0;
            err_cnt_q    <= '0;
            txn_q        <= '0;
            unm_q        <= '0;
            hit_q        <= '0;
            first_addr_q <= '0;
            first_exp_q  <= '0;
            first_act_q  <= '0;
        end else begin
            err_q        <= err_d;
            cfg_q        <= cfg_d;
            err_cnt_q    <= err_cnt_d;
            txn_q        <= txn_d;
            unm_q        <= unm_d;
            hit_q        <= hit_d;
            first_addr_q <= first_addr_d;
            first_exp_q  <= first_exp_d;
            first_act_q  <= first_act_d;
        end
    end

    assign o_err          = err_q;
    assign o_cfg_err      = cfg_q;
    assign o_err_cnt      = err_cnt_q;
    assign o_txn_cnt      = txn_q;
    assign o_unmapped_cnt = unm_q;
    assign o_hit_cnt      = hit_q;
    assign o_first_addr   = first_addr_q;
    assign o_first_exp    = first_exp_q;
    assign o_first_act    = first_act_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_scoreboard_lsu_region.sv
// Bench for scoreboard_lsu_region: four configurations (latency 0/2, stop-on-error,
// 4-bit saturating counters with overlapping regions).
module tb_scoreboard_lsu_region;
  import singlecycle_pkg::*;

  localparam int SNAP_W = 1 + 16 * 6;

  localparam logic [7:0][31:0] TB_BASE = {
    32'hF000_0700, 32'hF000_0600, 32'hF000_0500, 32'hF000_0400,
    32'hF000_0300, 32'h0000_7010, 32'h0000_7000, 32'h0000_2000
  };
  localparam logic [7:0][31:0] TB_SIZE = {
    32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd8, 32'd4, 32'h2000
  };
  localparam logic [7:0][31:0] OV_BASE = {
    32'hF000_0700, 32'hF000_0600, 32'hF000_0500, 32'hF000_0400,
    32'h0000_7000, 32'h0000_7010, 32'h0000_7000, 32'h0000_2000
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        drv_valid = 1'b0;
  logic [31:0] drv_addr = '0;
  logic        clr_a = 0, clr_b = 0, clr_c = 0, clr_d = 0;
  logic [7:0]  act_a = '0, act_b = '0, act_c = '0, act_d = '0;

  logic a_err, a_cfg, b_err, b_cfg, c_err, c_cfg, d_err, d_cfg;
  logic [15:0] a_errc, a_txn, a_unm, b_errc, b_txn, b_unm, c_errc, c_txn, c_unm;
  logic [3:0]  d_errc, d_txn, d_unm;
  logic [127:0] a_hit, b_hit, c_hit;
  logic [31:0]  d_hit;
  logic [31:0]  a_fa, b_fa, c_fa, d_fa;
  logic [7:0]   a_fe, a_fact, b_fe, b_fact, c_fe, c_fact, d_fe, d_fact;
  sb_state_e    a_st, b_st, c_st, d_st;

  scoreboard_lsu_region #(.LATENCY(0), .CNT_W(16), .REGION_BASE(TB_BASE), .REGION_SIZE(TB_SIZE),
                          .STOP_ON_ERR(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr_a), .i_drv_valid(drv_valid), .i_drv_addr(drv_addr),
    .i_act_vld(act_a), .o_err(a_err), .o_cfg_err(a_cfg), .o_err_cnt(a_errc), .o_txn_cnt(a_txn),
    .o_unmapped_cnt(a_unm), .o_hit_cnt(a_hit), .o_first_addr(a_fa), .o_first_exp(a_fe),
    .o_first_act(a_fact), .o_state(a_st));

  scoreboard_lsu_region #(.LATENCY(2), .CNT_W(16), .REGION_BASE(TB_BASE), .REGION_SIZE(TB_SIZE),
                          .STOP_ON_ERR(1'b0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr_b), .i_drv_valid(drv_valid), .i_drv_addr(drv_addr),
    .i_act_vld(act_b), .o_err(b_err), .o_cfg_err(b_cfg), .o_err_cnt(b_errc), .o_txn_cnt(b_txn),
    .o_unmapped_cnt(b_unm), .o_hit_cnt(b_hit), .o_first_addr(b_fa), .o_first_exp(b_fe),
    .o_first_act(b_fact), .o_state(b_st));

  scoreboard_lsu_region #(.LATENCY(0), .CNT_W(16), .REGION_BASE(TB_BASE), .REGION_SIZE(TB_SIZE),
                          .STOP_ON_ERR(1'b1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr_c), .i_drv_valid(drv_valid), .i_drv_addr(drv_addr),
    .i_act_vld(act_c), .o_err(c_err), .o_cfg_err(c_cfg), .o_err_cnt(c_errc), .o_txn_cnt(c_txn),
    .o_unmapped_cnt(c_unm), .o_hit_cnt(c_hit), .o_first_addr(c_fa), .o_first_exp(c_fe),
    .o_first_act(c_fact), .o_state(c_st));

  scoreboard_lsu_region #(.LATENCY(0), .CNT_W(4), .REGION_BASE(OV_BASE), .REGION_SIZE(TB_SIZE),
                          .STOP_ON_ERR(1'b0)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr_d), .i_drv_valid(drv_valid), .i_drv_addr(drv_addr),
    .i_act_vld(act_d), .o_err(d_err), .o_cfg_err(d_cfg), .o_err_cnt(d_errc), .o_txn_cnt(d_txn),
    .o_unmapped_cnt(d_unm), .o_hit_cnt(d_hit), .o_first_addr(d_fa), .o_first_exp(d_fe),
    .o_first_act(d_fact), .o_state(d_st));

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [SNAP_W-1:0] exp_q[$];

  int          m_txn, m_unm, m_errc;
  int          m_hit[3];
  logic        m_err;
  logic [31:0] m_fa;
  logic [7:0]  m_fe, m_fact;

  typedef struct packed {
    logic        v;
    logic [31:0] addr;
    logic [7:0]  exp_sel;
    logic [7:0]  act;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_valid = 1'b0; drv_addr = '0;
    act_a = '0; act_b = '0; act_c = '0; act_d = '0;
    clr_a = 0; clr_b = 0; clr_c = 0; clr_d = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] ref_decode(input logic v, input logic [31:0] a);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      longint unsigned lo;
      longint unsigned hi;
      lo = longint'(TB_BASE[k]);
      hi = lo + longint'(TB_SIZE[k]);
      if (v && (longint'(a) >= lo) && (longint'(a) < hi)) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [SNAP_W-1:0] model_snap();
    return {m_err, 16'(m_errc), 16'(m_txn), 16'(m_unm), 16'(m_hit[0]), 16'(m_hit[1]), 16'(m_hit[2])};
  endfunction

  function automatic logic [SNAP_W-1:0] dut_snap();
    return {a_err, a_errc, a_txn, a_unm, a_hit[0 +: 16], a_hit[16 +: 16], a_hit[32 +: 16]};
  endfunction

  task automatic model_step(input logic v, input logic [31:0] a, input logic [7:0] e,
                            input logic [7:0] act);
    if (v) m_txn++;
    if (v && e == 8'h00) m_unm++;
    for (int k = 0; k < 3; k++) if (e[k]) m_hit[k]++;
    if (e != act) begin
      m_errc++;
      if (!m_err) begin
        m_fa = a; m_fe = e; m_fact = act;
      end
      m_err = 1'b1;
    end
  endtask

  // drive one cycle on instance A, push the expected snapshot, compare after the edge
  task automatic sb_cycle(input string name, input logic v, input logic [31:0] a,
                          input logic [7:0] e, input logic [7:0] act);
    logic [SNAP_W-1:0] want;
    drv_valid = v; drv_addr = a; act_a = act;
    model_step(v, a, e, act);
    exp_q.push_back(model_snap());
    tick();
    want = exp_q.pop_front();
    check(name, dut_snap(), want);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_2004, 8'h01, 8'h01};
    vecs[1]  = '{1'b1, 32'h0000_7017, 8'h04, 8'h04};
    vecs[2]  = '{1'b1, 32'h0000_7018, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 32'h0000_1FFF, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 32'h0000_3FFF, 8'h01, 8'h01};
    vecs[5]  = '{1'b1, 32'h0000_4000, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 32'h0000_2004, 8'h00, 8'h00};
    vecs[7]  = '{1'b1, 32'h0000_7000, 8'h02, 8'h02};
    vecs[8]  = '{1'b1, 32'h0000_7003, 8'h02, 8'h02};
    vecs[9]  = '{1'b1, 32'h0000_7004, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 32'h0000_7010, 8'h04, 8'h04};
    vecs[11] = '{1'b1, 32'hFFFF_FFFF, 8'h00, 8'h00};
    vecs[12] = '{1'b1, 32'h0000_2000, 8'h01, 8'h00};
    vecs[13] = '{1'b1, 32'h0000_7014, 8'h04, 8'h04};

    m_txn = 0; m_unm = 0; m_errc = 0; m_err = 1'b0;
    m_fa = '0; m_fe = '0; m_fact = '0;
    for (int k = 0; k < 3; k++) m_hit[k] = 0;

    // ---- reset state, latency 0 table ----
    do_reset();
    check("rst_err", a_err, 0);
    check("rst_cfg", a_cfg, 0);
    check("rst_txn", a_txn, 0);
    check("rst_hit", a_hit, 0);
    check("rst_state", a_st, ST_RUN);

    for (int i = 0; i < 14; i++) begin
      check($sformatf("tbl_decode[%0d]", i), ref_decode(vecs[i].v, vecs[i].addr), vecs[i].exp_sel);
      sb_cycle($sformatf("tbl[%0d]", i), vecs[i].v, vecs[i].addr, vecs[i].exp_sel, vecs[i].act);
    end
    check("tbl_first_addr", a_fa, 32'h0000_2000);
    check("tbl_first_exp", a_fe, 8'h01);
    check("tbl_first_act", a_fact, 8'h00);
    check("tbl_state", a_st, ST_LOGGED);

    // ---- random boundary-heavy traffic on the same instance ----
    for (int i = 0; i < 40; i++) begin
      logic [31:0] pool[12];
      logic [31:0] a;
      logic        v;
      logic [7:0]  e;
      logic [7:0]  act;
      pool = '{32'h1FFF, 32'h2000, 32'h3FFF, 32'h4000, 32'h6FFF, 32'h7000,
               32'h7003, 32'h7004, 32'h700F, 32'h7010, 32'h7017, 32'h7018};
      a = pool[$urandom_range(0, 11)];
      v = ($urandom_range(0, 3) != 0);
      e = ref_decode(v, a);
      act = e;
      if ($urandom_range(0, 7) == 0) act = e ^ (8'h01 << $urandom_range(0, 7));
      sb_cycle($sformatf("rnd[%0d]", i), v, a, e, act);
    end
    check("rnd_first_addr", a_fa, m_fa);
    check("rnd_hit_unused", a_hit[127:48], 0);

    // ---- latency 2, correctly aligned ----
    do_reset();
    drv_valid = 1'b1; drv_addr = 32'h7010; tick();
    drv_valid = 1'b0; drv_addr = '0; tick();
    act_b = 8'h04; tick();
    act_b = 8'h00;
    check("l2_ok_err", b_err, 0);
    check("l2_ok_txn", b_txn, 1);
    check("l2_ok_hit2", b_hit[32 +: 16], 1);

    // ---- latency 2, select arrives one cycle early ----
    do_reset();
    drv_valid = 1'b1; drv_addr = 32'h2004; tick();
    drv_addr = 32'h7010; tick();
    drv_valid = 1'b0; drv_addr = '0; act_b = 8'h04; tick();
    act_b = 8'h04; tick();
    act_b = 8'h00; tick();
    check("l2_early_err", b_err, 1);
    check("l2_early_errcnt", b_errc, 1);
    check("l2_early_txn", b_txn, 2);
    check("l2_early_first_addr", b_fa, 32'h2004);
    check("l2_early_first_exp", b_fe, 8'h01);
    check("l2_early_first_act", b_fact, 8'h04);
    check("l2_early_state", b_st, ST_LOGGED);

    // ---- reset with an entry in flight ----
    drv_valid = 1'b1; drv_addr = 32'h7010; tick();
    drv_valid = 1'b0; drv_addr = '0; rst_n = 1'b0; tick();
    check("midrst_err", b_err, 0);
    check("midrst_errcnt", b_errc, 0);
    check("midrst_txn", b_txn, 0);
    check("midrst_first_addr", b_fa, 0);
    check("midrst_state", b_st, ST_RUN);
    rst_n = 1'b1; tick(); tick(); tick();
    check("midrst_flush_err", b_err, 0);
    check("midrst_flush_txn", b_txn, 0);

    // ---- stop on error ----
    do_reset();
    drv_valid = 1'b1; drv_addr = 32'h2004; act_c = 8'h00; tick();
    check("stop_state", c_st, ST_FAIL);
    check("stop_err", c_err, 1);
    check("stop_errcnt", c_errc, 1);
    check("stop_txn", c_txn, 1);
    act_c = 8'h01;
    for (int i = 0; i < 10; i++) tick();
    act_c = 8'h00; tick();
    check("stop_frozen_txn", c_txn, 1);
    check("stop_frozen_hit0", c_hit[0 +: 16], 1);
    check("stop_frozen_errcnt", c_errc, 1);
    check("stop_frozen_state", c_st, ST_FAIL);
    drv_valid = 1'b0; drv_addr = '0; clr_c = 1; tick();
    clr_c = 0;
    check("clr_state", c_st, ST_RUN);
    check("clr_err", c_err, 0);
    check("clr_txn", c_txn, 0);
    check("clr_errcnt", c_errc, 0);
    check("clr_first_addr", c_fa, 0);
    // clear coinciding with a mismatch: the mismatch is dropped
    drv_valid = 1'b1; drv_addr = 32'h2004; act_c = 8'h00; clr_c = 1; tick();
    clr_c = 0;
    check("clrmis_err", c_err, 0);
    check("clrmis_errcnt", c_errc, 0);
    check("clrmis_state", c_st, ST_RUN);
    act_c = 8'h01; tick();
    check("after_clr_txn", c_txn, 1);
    check("after_clr_err", c_err, 0);

    // ---- 4-bit saturation with overlapping r1/r3 ----
    do_reset();
    check("sat_cfg_rst", d_cfg, 0);
    drv_valid = 1'b1; drv_addr = 32'h7000; act_d = 8'h0A;
    for (int i = 0; i < 20; i++) tick();
    drv_valid = 1'b0; drv_addr = '0; act_d = 8'h00; tick();
    check("sat_hit1", d_hit[4 +: 4], 4'd15);
    check("sat_hit3", d_hit[12 +: 4], 4'd15);
    check("sat_txn", d_txn, 4'd15);
    check("sat_cfg", d_cfg, 1);
    check("sat_err", d_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
